// File: rtl/uart_ser_pkg.sv
// Shared types and helpers for the parametrised UART TX serializer.
// The optional hold buffer is enabled by defining UART_SER_HOLD_BUF_EN.
package uart_ser_pkg;

  typedef enum logic [1:0] {
    SER_IDLE   = 2'd0,
    SER_LOADED = 2'd1,
    SER_SHIFT  = 2'd2
  } ser_state_e;

  localparam bit SER_LSB_FIRST = 1'b1;
  localparam bit SER_MSB_FIRST = 1'b0;

  // Bit counter width; clamped to 1 so tiny widths still get a usable counter.
  function automatic int SER_CNT_W(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/uart_ser_hold_buf.sv
// One-word hold buffer for back-to-back frames in the UART TX serializer.
// Instantiated by uart_ser_param only when UART_SER_HOLD_BUF_EN is defined.
module uart_ser_hold_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] hold_data,
  output logic                  hold_valid,
  output logic                  ready
);

  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;

  // Writes only happen while empty and reads only while full, so they never collide.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_r  <= {DATA_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (wr_en) begin
      data_r  <= wr_data;
      valid_r <= 1'b1;
    end else if (rd_en) begin
      valid_r <= 1'b0;
    end
  end

  // Buffer status outputs.
  always_comb begin
    hold_data  = data_r;
    hold_valid = valid_r;
    ready      = !valid_r;
  end

endmodule

// File: rtl/uart_ser_param.sv
// Parametrised UART TX serializer: handshake load, pausable shift-out, frame copy for parity.
// Define UART_SER_HOLD_BUF_EN to add the one-word hold buffer for back-to-back frames.
module uart_ser_param
  import uart_ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = SER_LSB_FIRST
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  output logic                  load_ready,
  input  logic                  ser_en,
  output logic                  ser_data,
  output logic                  ser_done,
  output logic                  ser_busy,
  output logic [DATA_WIDTH-1:0] frame_data
);

  localparam int               CNT_W    = SER_CNT_W(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam bit               OUT_LSB  = (LSB_FIRST != SER_MSB_FIRST);

  localparam logic [1:0] IDLE   = SER_IDLE;
  localparam logic [1:0] LOADED = SER_LOADED;
  localparam logic [1:0] SHIFT  = SER_SHIFT;

  logic [1:0]            state_r, state_nx_s;
  logic [DATA_WIDTH-1:0] shreg_r, shreg_nx_s;
  logic [DATA_WIDTH-1:0] frame_r, frame_nx_s;
  logic [CNT_W-1:0]      cnt_r, cnt_nx_s;

  logic                  accept_s;
  logic                  done_s;
  logic                  active_s;
  logic                  reload_s;
  logic [DATA_WIDTH-1:0] reload_data_s;

  // Handshake and end-of-frame decode.
  always_comb begin
    active_s = (state_r != IDLE);
    accept_s = Data_Valid && load_ready;
    done_s   = ser_en && (cnt_r == CNT_LAST) && active_s;
  end

`ifdef UART_SER_HOLD_BUF_EN
  logic                  hold_wr_s;
  logic                  hold_rd_s;
  logic                  hold_valid_s;
  logic [DATA_WIDTH-1:0] hold_data_s;

  // Mid-frame accepts park in the hold buffer; on the last bit either the parked
  // word or a same-cycle accept goes straight into the shifter.
  always_comb begin
    hold_wr_s     = accept_s && active_s && !done_s;
    hold_rd_s     = done_s && hold_valid_s;
    reload_s      = hold_valid_s || accept_s;
    reload_data_s = hold_valid_s ? hold_data_s : P_Data;
  end

  uart_ser_hold_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold_buf (
    .CLK        (CLK),
    .RST        (RST),
    .wr_en      (hold_wr_s),
    .rd_en      (hold_rd_s),
    .wr_data    (P_Data),
    .hold_data  (hold_data_s),
    .hold_valid (hold_valid_s),
    .ready      (load_ready)
  );
`else
  // Single-buffered: only an idle block accepts, so a frame always ends in IDLE.
  always_comb begin
    load_ready    = (state_r == IDLE);
    reload_s      = 1'b0;
    reload_data_s = P_Data;
  end
`endif

  // Next-state logic: load, shift one bit per enabled cycle, pause otherwise.
  always_comb begin
    state_nx_s = state_r;
    shreg_nx_s = shreg_r;
    frame_nx_s = frame_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = LOADED;
          shreg_nx_s = P_Data;
          frame_nx_s = P_Data;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOADED, SHIFT: begin
        if (done_s) begin
          if (reload_s) begin
            state_nx_s = LOADED;
            shreg_nx_s = reload_data_s;
            frame_nx_s = reload_data_s;
            cnt_nx_s   = CNT_ZERO;
          end else begin
            state_nx_s = IDLE;
          end
        end else if (ser_en) begin
          state_nx_s = SHIFT;
          cnt_nx_s   = cnt_r + CNT_ONE;
          if (OUT_LSB) begin
            shreg_nx_s = {1'b0, shreg_r[DATA_WIDTH-1:1]};
          end else begin
            shreg_nx_s = {shreg_r[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      shreg_r <= {DATA_WIDTH{1'b0}};
      frame_r <= {DATA_WIDTH{1'b0}};
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nx_s;
      shreg_r <= shreg_nx_s;
      frame_r <= frame_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Line idles high; otherwise the output end of the shifter drives the line.
  always_comb begin
    if (state_r == IDLE) begin
      ser_data = 1'b1;
    end else if (OUT_LSB) begin
      ser_data = shreg_r[0];
    end else begin
      ser_data = shreg_r[DATA_WIDTH-1];
    end
  end

  // Status outputs.
  always_comb begin
    ser_done   = done_s;
    ser_busy   = active_s;
    frame_data = frame_r;
  end

endmodule

// File: tb/tb_uart_ser_param.sv
// Self-checking bench for uart_ser_param: frame-level model plus directed literal vectors.
`timescale 1ns/1ps
module tb_uart_ser_param;

  logic       CLK = 1'b0;
  logic       RST;

  logic [7:0] pd_a;
  logic       dv_a, en_a;
  logic       ld_a, sd_a, done_a, busy_a;
  logic [7:0] fd_a;

  logic [6:0] pd_b;
  logic       dv_b, en_b;
  logic       ld_b, sd_b, done_b, busy_b;
  logic [6:0] fd_b;

  int checks = 0;
  int errors = 0;
  logic started = 1'b0;

  always #5 CLK = ~CLK;

  uart_ser_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .P_Data(pd_a), .Data_Valid(dv_a), .load_ready(ld_a),
    .ser_en(en_a), .ser_data(sd_a), .ser_done(done_a), .ser_busy(busy_a), .frame_data(fd_a)
  );

  uart_ser_param #(.DATA_WIDTH(7), .LSB_FIRST(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .P_Data(pd_b), .Data_Valid(dv_b), .load_ready(ld_b),
    .ser_en(en_b), .ser_data(sd_b), .ser_done(done_b), .ser_busy(busy_b), .frame_data(fd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame-level model of DUT A: which word is on the line and how many bits have gone.
  logic       m_busy = 1'b0;
  logic       m_hold = 1'b0;
  int         m_k = 0;
  logic [7:0] m_word = 8'h00;
  logic [7:0] m_frame = 8'h00;
  logic [7:0] m_hold_word = 8'h00;
  logic       m_ready, m_acc, m_done;

`ifdef UART_SER_HOLD_BUF_EN
  assign m_ready = !m_hold;
`else
  assign m_ready = !m_busy;
`endif
  assign m_acc  = dv_a && m_ready;
  assign m_done = en_a && m_busy && (m_k == 7);

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_busy <= 1'b0; m_hold <= 1'b0; m_k <= 0; m_word <= 8'h00; m_frame <= 8'h00;
    end else if (!m_busy) begin
      if (m_acc) begin
        m_busy <= 1'b1; m_word <= pd_a; m_frame <= pd_a; m_k <= 0;
      end
    end else if (m_done) begin
      if (m_hold) begin
        m_word <= m_hold_word; m_frame <= m_hold_word; m_k <= 0; m_hold <= 1'b0;
      end else if (m_acc) begin
        m_word <= pd_a; m_frame <= pd_a; m_k <= 0;
      end else begin
        m_busy <= 1'b0;
      end
    end else begin
      if (en_a) m_k <= m_k + 1;
      if (m_acc) begin
        m_hold <= 1'b1; m_hold_word <= pd_a;
      end
    end
  end

  // Compare DUT A against the model every cycle once the run is under way.
  always @(negedge CLK) begin
    if (started) begin
      check("cmp_ser_data", sd_a, m_busy ? m_word[m_k] : 1'b1);
      check("cmp_ser_done", done_a, m_done);
      check("cmp_ser_busy", busy_a, m_busy);
      check("cmp_load_ready", ld_a, m_ready);
      check("cmp_frame_data", fd_a, m_frame);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  // Load a word on A and send it with ser_en held; seq lists expected bits in time order (MSB of seq first).
  task automatic send_a(input logic [7:0] w, input logic [7:0] seq);
    dv_a = 1'b1; pd_a = w; en_a = 1'b0;
    tick();
    dv_a = 1'b0;
    #1;
    check("lit_loaded_busy", busy_a, 1'b1);
    check("lit_first_bit", sd_a, seq[7]);
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1;
      #1;
      check("lit_a_bit", sd_a, seq[7-i]);
      check("lit_a_done", done_a, (i == 7));
      tick();
    end
    en_a = 1'b0;
    #1;
    check("lit_a_busy_after", busy_a, 1'b0);
    check("lit_a_frame", fd_a, w);
    check("lit_a_idle_line", sd_a, 1'b1);
  endtask

  initial begin
    logic [7:0] seq;
    logic [6:0] seqb;
    RST = 1'b0;
    dv_a = 1'b0; en_a = 1'b0; pd_a = 8'h00;
    dv_b = 1'b0; en_b = 1'b0; pd_b = 7'h00;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_ser_data", sd_a, 1'b1);
    check("rst_ser_done", done_a, 1'b0);
    check("rst_ser_busy", busy_a, 1'b0);
    check("rst_load_ready", ld_a, 1'b1);
    check("rst_frame_data", fd_a, 8'h00);
    check("rst_b_ser_data", sd_b, 1'b1);
    check("rst_b_load_ready", ld_b, 1'b1);
    started = 1'b1;
    RST = 1'b1;
    tick();

    // 8'hA5 LSB first: 1,0,1,0,0,1,0,1
    send_a(8'hA5, 8'b1010_0101);

    // DUT B: 7'h51 MSB first: 1,0,1,0,0,0,1
    seqb = 7'b101_0001;
    dv_b = 1'b1; pd_b = 7'h51;
    tick();
    dv_b = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en_b = 1'b1;
      #1;
      check("lit_b_bit", sd_b, seqb[6-i]);
      check("lit_b_done", done_b, (i == 6));
      tick();
    end
    en_b = 1'b0;
    #1;
    check("lit_b_busy_after", busy_b, 1'b0);
    check("lit_b_frame", fd_b, 7'h51);

    // 8'h0F with a 3-cycle pause after three bits: 1,1,1,(pause on 1),1,0,0,0,0
    seq = 8'b1111_0000;
    dv_a = 1'b1; pd_a = 8'h0F;
    tick();
    dv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int p = 0; p < 3; p++) begin
          en_a = 1'b0;
          #1;
          check("lit_pause_bit", sd_a, 1'b1);
          check("lit_pause_done", done_a, 1'b0);
          check("lit_pause_busy", busy_a, 1'b1);
          tick();
        end
      end
      en_a = 1'b1;
      #1;
      check("lit_0f_bit", sd_a, seq[7-i]);
      check("lit_0f_done", done_a, (i == 7));
      tick();
    end
    en_a = 1'b0;
    #1;
    check("lit_0f_busy_after", busy_a, 1'b0);

`ifndef UART_SER_HOLD_BUF_EN
    // Mid-frame offer of 8'hFF is refused and the A5 frame is undisturbed.
    seq = 8'b1010_0101;
    dv_a = 1'b1; pd_a = 8'hA5;
    tick();
    dv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1;
      if (i == 3) begin
        dv_a = 1'b1; pd_a = 8'hFF;
        #1;
        check("lit_drop_ready", ld_a, 1'b0);
      end else begin
        dv_a = 1'b0;
      end
      #1;
      check("lit_drop_bit", sd_a, seq[7-i]);
      check("lit_drop_frame", fd_a, 8'hA5);
      check("lit_drop_done", done_a, (i == 7));
      tick();
    end
    dv_a = 1'b0; en_a = 1'b0;
    #1;
    check("lit_drop_busy_after", busy_a, 1'b0);
`else
    // 8'h12 in flight, 8'h34 parked mid-frame, then sent back-to-back.
    dv_a = 1'b1; pd_a = 8'h12;
    tick();
    dv_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1;
      if (i == 2) begin
        dv_a = 1'b1; pd_a = 8'h34;
        #1;
        check("lit_hold_ready_before", ld_a, 1'b1);
      end else begin
        dv_a = 1'b0;
      end
      #1;
      if (i > 2) check("lit_hold_ready_low", ld_a, 1'b0);
      check("lit_hold_done1", done_a, (i == 7));
      tick();
    end
    dv_a = 1'b0; en_a = 1'b0;
    #1;
    check("lit_hold_busy", busy_a, 1'b1);
    check("lit_hold_frame", fd_a, 8'h34);
    check("lit_hold_ready_back", ld_a, 1'b1);
    check("lit_hold_first_bit", sd_a, 1'b0);
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1;
      #1;
      check("lit_hold_done2", done_a, (i == 7));
      tick();
    end
    en_a = 1'b0;
    #1;
    check("lit_hold_busy_after", busy_a, 1'b0);
`endif

    // 8'hC3 (1,1,0,0,0,0,1,1) aborted by reset at bit 4.
    seq = 8'b1100_0011;
    dv_a = 1'b1; pd_a = 8'hC3;
    tick();
    dv_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en_a = 1'b1;
      #1;
      check("lit_c3_bit", sd_a, seq[7-i]);
      tick();
    end
    en_a = 1'b1;
    #1;
    check("lit_c3_bit4", sd_a, seq[3]);
    RST = 1'b0;
    #1;
    check("lit_abort_ser_data", sd_a, 1'b1);
    check("lit_abort_busy", busy_a, 1'b0);
    check("lit_abort_ready", ld_a, 1'b1);
    check("lit_abort_done", done_a, 1'b0);
    en_a = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    send_a(8'hA5, 8'b1010_0101);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_ser_param.md
# uart_ser_param

Parametrised UART TX serializer: captures a parallel word on a valid/ready handshake, holds it stable for the parity block, and shifts it out one bit per enabled cycle. It sits between the TX data source and the TX output mux and is driven by the TX controller FSM through `ser_en`. It adds configurable width and bit order, pause-on-deassert of `ser_en`, and an optional one-word hold buffer for back-to-back frames.

## Interface
- `DATA_WIDTH`, default 8: frame data bits, legal range 5..9.
- `LSB_FIRST`, default 1: 1 sends bit 0 first; 0 sends bit DATA_WIDTH-1 first.
- `CLK`  in  1  TX clock; all state updates on its rising edge.
- `RST`  in  1  reset, asynchronous, active-low.
- `P_Data`  in  DATA_WIDTH  parallel word to send.
- `Data_Valid`  in  1  `P_Data` offered this cycle.
- `load_ready`  out  1  block accepts `P_Data` this cycle.
- `ser_en`  in  1  advance one bit this cycle, from the TX FSM.
- `ser_data`  out  1  current serial bit.
- `ser_done`  out  1  last data bit is on `ser_data` this cycle.
- `ser_busy`  out  1  a frame is loaded or shifting.
- `frame_data`  out  DATA_WIDTH  unshifted copy of the word currently framed, for parity.

## Operation
- Accept occurs on a rising edge with `Data_Valid && load_ready`. `Data_Valid` without `load_ready` is ignored; the data is dropped and no state changes.
- Registers:
  - `shreg` (DATA_WIDTH): shift register.
  - `frame_data` (DATA_WIDTH).
  - `cnt` ($clog2(DATA_WIDTH) bits).
  - `state`.
- States:
  - IDLE to LOADED on accept: `shreg` and `frame_data` take `P_Data`; `cnt` is set to 0.
  - LOADED to SHIFT on the first cycle with `ser_en=1`. The bit presented on that cycle is bit 0 of the frame.
  - SHIFT: each cycle with `ser_en=1`, `shreg` shifts toward the output end and `cnt` increments.
  - SHIFT: `ser_en=0` pauses; `shreg` and `cnt` hold and `ser_data` holds the current bit.
  - End of frame: when `cnt==DATA_WIDTH-1` and `ser_en=1`, the next state is IDLE, or LOADED if a buffered word exists (see Configuration).
- `ser_data`:
  - 1 in IDLE.
  - Otherwise `shreg[0]` when `LSB_FIRST`, else `shreg[DATA_WIDTH-1]`.
- `ser_done = ser_en && cnt==DATA_WIDTH-1 && state!=IDLE`. It is combinational and high for exactly one enabled cycle per frame.
- `ser_busy = (state!=IDLE)`.
- `frame_data` is stable from accept until the next accept.
- `ser_en` high while in IDLE has no effect.
- `cnt` never wraps past DATA_WIDTH-1; it resets to 0 on every load.

## Timing
- Reset values: `state` IDLE, `shreg`/`frame_data`/`cnt` 0, hold buffer empty.
- Outputs in reset: `ser_data=1`, `ser_done=0`, `ser_busy=0`, `load_ready=1`.
- Reset asserted mid-frame aborts immediately. `ser_data` returns to 1 asynchronously and the word is lost.
- Accept to first bit: the word is on `ser_data` from the cycle after accept. The first enabled cycle presents bit 0.
- A frame with `ser_en` held high takes exactly DATA_WIDTH enabled cycles. `ser_done` is high on the DATA_WIDTH-th.

## Configuration
- Macro `UART_SER_HOLD_BUF_EN` adds a one-word hold buffer.
- Without `UART_SER_HOLD_BUF_EN`:
  - `load_ready = (state==IDLE)`.
  - After `ser_done` the block returns to IDLE for at least one cycle before the next accept.
- With `UART_SER_HOLD_BUF_EN`:
  - `load_ready = !hold_valid`.
  - Accept in IDLE loads `shreg` directly.
  - Accept in LOADED or SHIFT writes the hold register and sets `hold_valid`.
  - On the `ser_done` edge with `hold_valid`: the hold word moves to `shreg`/`frame_data`, `hold_valid` clears, `cnt=0`, and the state goes to LOADED.
  - On the `ser_done` edge with an accept and the hold buffer empty, the accepted word bypasses into `shreg`; the state goes to LOADED.

## Structure
- Package `uart_ser_pkg` contains:
  - the state enum (IDLE, LOADED, SHIFT);
  - the `SER_CNT_W(DATA_WIDTH)` width function;
  - the bit-order constants `SER_LSB_FIRST`/`SER_MSB_FIRST`.
- Sub-module `uart_ser_hold_buf` holds the register, valid flag and ready logic. It is instantiated only under `UART_SER_HOLD_BUF_EN`.

## Test plan
- Reset, then `P_Data=8'hA5`, `Data_Valid` for 1 cycle, `ser_en` high for 8 cycles, with `LSB_FIRST=1`:
  - `ser_data` = 1,0,1,0,0,1,0,1;
  - `ser_done` high on the 8th cycle only;
  - `frame_data=8'hA5`;
  - `ser_busy` low after.
- `DATA_WIDTH=7`, `LSB_FIRST=0`, `P_Data=7'h51` -> `ser_data` = 1,0,1,0,0,0,1 MSB first; `ser_done` on the 7th enabled cycle.
- `8'h0F` with `ser_en` dropped for 3 cycles after bit 3 -> `ser_data` holds 1 during the pause; the remaining bits 0,0,0,0 follow; total enabled cycles is 8.
- `Data_Valid` with `8'hFF` mid-frame, macro off -> `load_ready=0`; the word is dropped; the current frame is unchanged.
- Macro on, `8'h12` then `8'h34` offered mid-frame:
  - `load_ready` goes low;
  - after `ser_done` the block is LOADED with `frame_data=8'h34`;
  - a second `ser_done` follows after 8 more enabled cycles.
- `RST` pulled low at bit 4 of `8'hC3` -> `ser_data=1`, `ser_busy=0`, `load_ready=1` immediately; the next frame transmits cleanly.
